uart_parity_engine: RTL and testbench

- Parametrised successor to the UART TX parity calculator.
- Accepts a data word over a valid/ready handshake and latches the runtime data length (5..P_WIDTH bits typical) and parity mode.
- Computes parity bit-serially over the active bits, then presents the parity bit with a valid/ack handshake to the TX serializer FSM.
- Adds none/even/odd/mark/space modes, runtime word length, and explicit busy/ready flow control.

---
 rtl/uart_parity_engine_if.sv | 48 ++++
 rtl/uart_parity_engine.sv | 185 ++++++++++++++++++
 tb/tb_uart_parity_engine.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_parity_engine_if.sv
// -----------------------------------------------------------------------------
// uart_parity_engine_if
// Handshake bundle between a word source / TX serializer (master) and the
// parity engine (slave). RX_PAR_BIT and PAR_ERR exist only when the
// PARITY_CHECK_EN macro is defined.
// -----------------------------------------------------------------------------
interface uart_parity_engine_if #(
    parameter int P_WIDTH = 8,
    parameter int LEN_W   = $clog2(P_WIDTH + 1)
);
    logic [P_WIDTH-1:0] P_DATA;
    logic [LEN_W-1:0]   DATA_LEN;
    logic [2:0]         PAR_MODE;
    logic               DATA_VALID;
    logic               DATA_READY;
    logic               PAR_BIT;
    logic               PAR_NONE;
    logic               PAR_VALID;
    logic               PAR_ACK;
`ifdef PARITY_CHECK_EN
    logic               RX_PAR_BIT;
    logic               PAR_ERR;

    // Source and serializer side
    modport master (
        output P_DATA, DATA_LEN, PAR_MODE, DATA_VALID, PAR_ACK, RX_PAR_BIT,
        input  DATA_READY, PAR_BIT, PAR_NONE, PAR_VALID, PAR_ERR
    );

    // Parity engine side
    modport slave (
        input  P_DATA, DATA_LEN, PAR_MODE, DATA_VALID, PAR_ACK, RX_PAR_BIT,
        output DATA_READY, PAR_BIT, PAR_NONE, PAR_VALID, PAR_ERR
    );
`else
    // Source and serializer side
    modport master (
        output P_DATA, DATA_LEN, PAR_MODE, DATA_VALID, PAR_ACK,
        input  DATA_READY, PAR_BIT, PAR_NONE, PAR_VALID
    );

    // Parity engine side
    modport slave (
        input  P_DATA, DATA_LEN, PAR_MODE, DATA_VALID, PAR_ACK,
        output DATA_READY, PAR_BIT, PAR_NONE, PAR_VALID
    );
`endif
endinterface : uart_parity_engine_if

// File: rtl/uart_parity_engine.sv
// -----------------------------------------------------------------------------
// uart_parity_engine
// Accepts a data word, computes its parity bit-serially over the runtime
// number of active bits (clamped to P_WIDTH), then holds the result on a
// valid/ack handshake for the TX serializer.
// Modes: 0 none, 1 even, 2 odd, 3 mark, 4 space, 5..7 behave as none.
// Optional macro PARITY_CHECK_EN adds RX_PAR_BIT / PAR_ERR so the block can
// also check a received parity bit at the acknowledge edge.
// -----------------------------------------------------------------------------
module uart_parity_engine #(
    parameter int P_WIDTH = 8,
    parameter int LEN_W   = $clog2(P_WIDTH + 1)
) (
    input  logic                CLK,
    input  logic                RST,
    uart_parity_engine_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        PM_NONE  = 3'd0,
        PM_EVEN  = 3'd1,
        PM_ODD   = 3'd2,
        PM_MARK  = 3'd3,
        PM_SPACE = 3'd4
    } par_mode_e;

    // Unused encodings 5..7 collapse onto "none" so the rest of the logic
    // only ever sees the five legal modes.
    function automatic par_mode_e decode_mode(input logic [2:0] raw);
        par_mode_e m;
        case (raw)
            3'd1:    m = PM_EVEN;
            3'd2:    m = PM_ODD;
            3'd3:    m = PM_MARK;
            3'd4:    m = PM_SPACE;
            default: m = PM_NONE;
        endcase
        return m;
    endfunction

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(P_WIDTH);

    // State and datapath registers
    state_e             state_q,    state_d;
    logic [P_WIDTH-1:0] sh_q,       sh_d;
    logic [LEN_W-1:0]   len_q,      len_d;
    logic [LEN_W-1:0]   cnt_q,      cnt_d;
    logic               acc_q,      acc_d;
    par_mode_e          mode_q,     mode_d;
    logic               par_bit_q,  par_bit_d;
    logic               par_none_q, par_none_d;
`ifdef PARITY_CHECK_EN
    logic               par_err_q,  par_err_d;
`endif

    // Decoded view of the incoming word and helpers for the CALC step
    par_mode_e          in_mode;
    logic [LEN_W-1:0]   in_len;
    logic               in_serial;
    logic               acc_next;
    logic [LEN_W-1:0]   last_cnt;

    // Decode the offered word: legal mode, clamped length, serial-mode flag
    always_comb begin
        in_mode   = decode_mode(bus.PAR_MODE);
        in_len    = (bus.DATA_LEN > MAX_LEN) ? MAX_LEN : bus.DATA_LEN;
        in_serial = ((in_mode == PM_EVEN) || (in_mode == PM_ODD)) && (in_len != '0);
        acc_next  = acc_q ^ sh_q[0];
        last_cnt  = len_q - LEN_W'(1);
    end

    // State register and datapath registers, synchronous active-high reset
    // NOTE: every register here, the shift register included, is reset so an
    // aborted word leaves no residue; nothing in this block is a RAM, so a
    // full reset costs nothing structurally.
    always_ff @(posedge CLK) begin
        if (RST) begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge value of every other register, regardless of order.
            state_q    <= ST_IDLE;
            sh_q       <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            acc_q      <= 1'b0;
            mode_q     <= PM_NONE;
            par_bit_q  <= 1'b0;
            par_none_q <= 1'b0;
`ifdef PARITY_CHECK_EN
            par_err_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            sh_q       <= sh_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            mode_q     <= mode_d;
            par_bit_q  <= par_bit_d;
            par_none_q <= par_none_d;
`ifdef PARITY_CHECK_EN
            par_err_q  <= par_err_d;
`endif
        end
    end

    // Next-state and datapath update for the IDLE -> CALC -> DONE sequence
    always_comb begin
        // NOTE: every signal written here gets a hold default first, so no
        // branch can leave one unassigned and infer a latch.
        state_d    = state_q;
        sh_d       = sh_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        mode_d     = mode_q;
        par_bit_d  = par_bit_q;
        par_none_d = par_none_q;
`ifdef PARITY_CHECK_EN
        par_err_d  = par_err_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (bus.DATA_VALID) begin
                    sh_d       = bus.P_DATA;
                    len_d      = in_len;
                    mode_d     = in_mode;
                    acc_d      = 1'b0;
                    cnt_d      = '0;
                    par_none_d = (in_mode == PM_NONE);
`ifdef PARITY_CHECK_EN
                    par_err_d  = 1'b0;
`endif
                    if (in_serial) begin
                        state_d = ST_CALC;
                    end else begin
                        // Zero-length even/odd parity is that of an empty
                        // word: even gives 0, odd gives 1, same as space/mark.
                        state_d   = ST_DONE;
                        par_bit_d = (in_mode == PM_ODD) || (in_mode == PM_MARK);
                    end
                end
            end

            ST_CALC: begin
                acc_d = acc_next;
                sh_d  = sh_q >> 1;
                cnt_d = cnt_q + LEN_W'(1);
                if (cnt_q == last_cnt) begin
                    state_d   = ST_DONE;
                    par_bit_d = (mode_q == PM_ODD) ? ~acc_next : acc_next;
                end
            end

            ST_DONE: begin
                if (bus.PAR_ACK) begin
                    state_d   = ST_IDLE;
`ifdef PARITY_CHECK_EN
                    par_err_d = ~par_none_q & (bus.RX_PAR_BIT != par_bit_q);
`endif
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Handshake outputs decode straight from the state register
    assign bus.DATA_READY = (state_q == ST_IDLE);
    assign bus.PAR_VALID  = (state_q == ST_DONE);
    assign bus.PAR_BIT    = par_bit_q;
    assign bus.PAR_NONE   = par_none_q;
`ifdef PARITY_CHECK_EN
    assign bus.PAR_ERR    = par_err_q;
`endif

endmodule : uart_parity_engine

// File: tb/tb_uart_parity_engine.sv
// -----------------------------------------------------------------------------
// tb_uart_parity_engine
// Directed vector table, hand-written corner sequences and randomized words
// checked against a population-count reference model (P_WIDTH = 8).
// -----------------------------------------------------------------------------
module tb_uart_parity_engine;

    localparam int W  = 8;
    localparam int LW = $clog2(W + 1);

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    uart_parity_engine_if #(.P_WIDTH(W), .LEN_W(LW)) bus ();

    uart_parity_engine #(.P_WIDTH(W), .LEN_W(LW)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global watchdog
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [7:0] data;
        logic [3:0] len;
        logic [2:0] mode;
        bit         exp_bit;
        bit         exp_none;
        int         exp_lat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: parity from the count of ones in the active bits.
    // Latency is counted in clock edges after the accept edge.
    function automatic void ref_model(input logic [7:0] data, input int len, input int mode,
                                      output bit pbit, output bit pnone, output int lat);
        int n;
        int ones;
        int mask;
        n    = (len > W) ? W : len;
        mask = (1 << n) - 1;
        ones = $countones(int'(data) & mask);
        pnone = 1'b0;
        lat   = 0;
        case (mode)
            1: begin pbit = (ones % 2) == 1; lat = n; end
            2: begin pbit = (ones % 2) == 0; lat = n; end
            3: pbit = 1'b1;
            4: pbit = 1'b0;
            default: begin pbit = 1'b0; pnone = 1'b1; end
        endcase
    endfunction

    // One full transaction: offer, wait for PAR_VALID, hold, acknowledge
    task automatic run_word(input string name, input logic [7:0] data, input logic [3:0] len,
                            input logic [2:0] mode, input bit exp_bit, input bit exp_none,
                            input int exp_lat, input int ack_delay, input bit rx);
        int lat;
        @(negedge clk);
        check({name, " ready"}, bus.DATA_READY, 1);
        bus.P_DATA     = data;
        bus.DATA_LEN   = len;
        bus.PAR_MODE   = mode;
        bus.DATA_VALID = 1'b1;
`ifdef PARITY_CHECK_EN
        bus.RX_PAR_BIT = rx;
`endif
        @(posedge clk);
        #1;
        bus.DATA_VALID = 1'b0;
        bus.P_DATA     = ~data;
`ifdef PARITY_CHECK_EN
        check({name, " err clr"}, bus.PAR_ERR, 0);
`endif
        lat = 0;
        while (!bus.PAR_VALID && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({name, " lat"}, lat, exp_lat);
        check({name, " bit"}, bus.PAR_BIT, exp_bit);
        check({name, " none"}, bus.PAR_NONE, exp_none);
        check({name, " busy"}, bus.DATA_READY, 0);
        for (int i = 0; i < ack_delay; i++) begin
            @(posedge clk);
            #1;
            check({name, " hold"}, {bus.PAR_VALID, bus.PAR_BIT}, {1'b1, exp_bit});
        end
        @(negedge clk);
        bus.PAR_ACK = 1'b1;
        @(posedge clk);
        #1;
        bus.PAR_ACK = 1'b0;
        check({name, " ack"}, {bus.PAR_VALID, bus.DATA_READY}, 2'b01);
`ifdef PARITY_CHECK_EN
        check({name, " err"}, bus.PAR_ERR, {31'd0, ~exp_none & (rx != exp_bit)});
`endif
        if (rx) begin end
    endtask

    vec_t vecs [13];

    initial begin
        bit   pbit;
        bit   pnone;
        int   lat;
        logic [7:0] d;
        logic [3:0] l;
        logic [2:0] m;

        vecs[0]  = '{8'hA5, 4'd8,  3'd1, 1'b0, 1'b0, 8};
        vecs[1]  = '{8'hA5, 4'd8,  3'd2, 1'b1, 1'b0, 8};
        vecs[2]  = '{8'hFF, 4'd5,  3'd1, 1'b1, 1'b0, 5};
        vecs[3]  = '{8'hA5, 4'd8,  3'd3, 1'b1, 1'b0, 0};
        vecs[4]  = '{8'hA5, 4'd8,  3'd4, 1'b0, 1'b0, 0};
        vecs[5]  = '{8'hA5, 4'd8,  3'd0, 1'b0, 1'b1, 0};
        vecs[6]  = '{8'hA5, 4'd8,  3'd6, 1'b0, 1'b1, 0};
        vecs[7]  = '{8'hFF, 4'd0,  3'd1, 1'b0, 1'b0, 0};
        vecs[8]  = '{8'hFF, 4'd0,  3'd2, 1'b1, 1'b0, 0};
        vecs[9]  = '{8'hA5, 4'd15, 3'd1, 1'b0, 1'b0, 8};
        vecs[10] = '{8'h80, 4'd7,  3'd1, 1'b0, 1'b0, 7};
        vecs[11] = '{8'h01, 4'd1,  3'd2, 1'b0, 1'b0, 1};
        vecs[12] = '{8'h7F, 4'd9,  3'd2, 1'b0, 1'b0, 8};

        rst            = 1'b1;
        bus.P_DATA     = '0;
        bus.DATA_LEN   = '0;
        bus.PAR_MODE   = '0;
        bus.DATA_VALID = 1'b0;
        bus.PAR_ACK    = 1'b0;
`ifdef PARITY_CHECK_EN
        bus.RX_PAR_BIT = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset state", {bus.DATA_READY, bus.PAR_VALID, bus.PAR_BIT, bus.PAR_NONE}, 4'b1000);
`ifdef PARITY_CHECK_EN
        check("reset err", bus.PAR_ERR, 0);
`endif

        // Directed vector table
        foreach (vecs[i])
            run_word($sformatf("vec%0d", i), vecs[i].data, vecs[i].len, vecs[i].mode,
                     vecs[i].exp_bit, vecs[i].exp_none, vecs[i].exp_lat, i % 3, 1'b0);

        // Inputs and PAR_ACK toggled during CALC, long hold in DONE
        @(negedge clk);
        bus.P_DATA = 8'hA5; bus.DATA_LEN = 4'd8; bus.PAR_MODE = 3'd1; bus.DATA_VALID = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus.P_DATA     = 8'($urandom);
            bus.DATA_LEN   = 4'($urandom);
            bus.PAR_MODE   = 3'($urandom);
            bus.DATA_VALID = 1'b1;
            bus.PAR_ACK    = 1'($urandom);
            @(posedge clk);
            #1;
            check("calc busy", {bus.DATA_READY, bus.PAR_VALID}, {1'b0, (i == 7)});
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.P_DATA     = 8'($urandom);
            bus.DATA_VALID = 1'b1;
            bus.PAR_ACK    = 1'b0;
            @(posedge clk);
            #1;
            check("done hold", {bus.DATA_READY, bus.PAR_VALID, bus.PAR_BIT, bus.PAR_NONE}, 4'b0100);
        end
        @(negedge clk);
        bus.DATA_VALID = 1'b0;
        bus.PAR_ACK    = 1'b1;
        @(posedge clk);
        #1;
        bus.PAR_ACK = 1'b0;
        check("hold ack", {bus.DATA_READY, bus.PAR_VALID}, 2'b10);
        @(posedge clk);
        #1;
        check("no second accept", {bus.DATA_READY, bus.PAR_VALID}, 2'b10);

        // Reset at CALC cycle 3 aborts the word
        @(negedge clk);
        bus.P_DATA = 8'hA5; bus.DATA_LEN = 4'd8; bus.PAR_MODE = 3'd1; bus.DATA_VALID = 1'b1;
        @(posedge clk);
        #1;
        bus.DATA_VALID = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mid reset", {bus.DATA_READY, bus.PAR_VALID, bus.PAR_BIT}, 3'b100);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("aborted no valid", bus.PAR_VALID, 0);
        end

        // Reset wins over DATA_VALID
        @(negedge clk);
        bus.PAR_MODE = 3'd3; bus.DATA_VALID = 1'b1; rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0; bus.DATA_VALID = 1'b0;
        check("rst vs valid", {bus.DATA_READY, bus.PAR_VALID}, 2'b10);

        // Reset wins over PAR_ACK: PAR_BIT must return to 0
        @(negedge clk);
        bus.PAR_MODE = 3'd3; bus.DATA_VALID = 1'b1;
        @(posedge clk);
        #1;
        bus.DATA_VALID = 1'b0;
        check("mark done", {bus.PAR_VALID, bus.PAR_BIT}, 2'b11);
        @(negedge clk);
        bus.PAR_ACK = 1'b1; rst = 1'b1;
        @(posedge clk);
        #1;
        bus.PAR_ACK = 1'b0; rst = 1'b0;
        check("rst vs ack", {bus.DATA_READY, bus.PAR_VALID, bus.PAR_BIT}, 3'b100);

`ifdef PARITY_CHECK_EN
        // Received parity mismatch flags PAR_ERR, next accept clears it
        run_word("rx err", 8'hA5, 4'd8, 3'd1, 1'b0, 1'b0, 8, 0, 1'b1);
        run_word("rx ok", 8'hA5, 4'd8, 3'd2, 1'b1, 1'b0, 8, 0, 1'b1);
        run_word("rx none", 8'hA5, 4'd8, 3'd0, 1'b0, 1'b1, 0, 0, 1'b1);
`endif

        // Randomized words against the reference model
        for (int i = 0; i < 200; i++) begin
            d = 8'($urandom);
            l = 4'($urandom_range(0, 15));
            m = 3'($urandom_range(0, 7));
            ref_model(d, int'(l), int'(m), pbit, pnone, lat);
            run_word("rand", d, l, m, pbit, pnone, lat, $urandom_range(0, 3), 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_uart_parity_engine
